// File: rtl/shift_pkg.sv
// Shared types for the shift unit: operation encoding and controller states.
package shift_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    LLS = 2'b00,
    LRS = 2'b01,
    ARS = 2'b10,
    ROL = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/shift_step.sv
// One-bit shift/rotate step, purely combinational.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mode_e              mode,
  input  logic [WIDTH-1:0]   value,
  output logic [WIDTH-1:0]   shifted
);

  always_comb begin
    shifted = value;
    case (mode)
      LLS:     shifted = {value[WIDTH-2:0], 1'b0};
      LRS:     shifted = {1'b0, value[WIDTH-1:1]};
      ARS:     shifted = {value[WIDTH-1], value[WIDTH-1:1]};
      ROL:     shifted = {value[WIDTH-2:0], value[WIDTH-1]};
      default: shifted = value;
    endcase
  end

endmodule

// File: rtl/shift_unit.sv
// Sequential shifter: one bit position per cycle, busy while shifting,
// single-cycle done pulse when the result is ready.
//
// state | meaning
// IDLE  | waiting for start, result holds last value
// SHIFT | applying one step per cycle, counter counts down to 0
// DONE  | result valid, done high; start here chains the next operation
module shift_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [AW-1:0]    amount,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic             done
);

  state_e           state_q,  state_d;
  mode_e            mode_q,   mode_d;
  logic [AW-1:0]    cnt_q,    cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_q,   done_d;

  logic [WIDTH-1:0] stepped;
  logic             accept;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .mode    (mode_q),
    .value   (result_q),
    .shifted (stepped)
  );

  assign accept = start && (state_q != SHIFT);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      mode_q   <= LLS;
      cnt_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    if (accept) begin
      result_d = data;
      mode_d   = mode_e'(mode);
      cnt_d    = amount;
      state_d  = (amount == '0) ? DONE : SHIFT;
    end else begin
      case (state_q)
        SHIFT: begin
          result_d = stepped;
          cnt_d    = cnt_q - AW'(1);
          if (cnt_q == AW'(1)) state_d = DONE;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    // done is registered so it is exactly coincident with the DONE state
    done_d = (state_d == DONE);
  end

  always_comb begin
    busy   = (state_q == SHIFT);
    done   = done_q;
    result = result_q;
  end

endmodule
